// File: rtl/fp_cvt_pkg.sv
// Shared constants, encodings and payload layout for the linear-to-float converter.
package fp_cvt_pkg;

    localparam int unsigned EW_DEF = 3;
    localparam int unsigned MW_DEF = 4;
    localparam int unsigned DW_DEF = (2 ** EW_DEF) + MW_DEF;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    // Stage payload at default widths (union of the fields used across the stages).
    typedef struct packed {
        logic              s;
        logic              sat;
        logic              rnd;
        logic [DW_DEF-1:0] mag;
        logic [EW_DEF-1:0] e;
        logic [MW_DEF-1:0] f;
        logic              rbit;
    } fp_stage_t;

    // Input width implied by an exponent/significand split.
    function automatic int unsigned fp_dw(input int unsigned ew, input int unsigned mw);
        return (2 ** ew) + mw;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; all-zero input yields DW.
module fp_lzc
    import fp_cvt_pkg::*;
#(
    parameter  int unsigned DW = DW_DEF,
    localparam int unsigned CW = $clog2(DW + 1)
) (
    input  logic [DW-1:0] data,
    output logic [CW-1:0] lz_c
);

    // Scan upwards so the highest set bit determines the count.
    always_comb begin
        lz_c = CW'(DW);
        for (int unsigned i = 0; i < DW; i++) begin
            if (data[i]) begin
                lz_c = CW'(DW - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_cvt_pipe.sv
// Three-stage linear-to-float converter: sign/magnitude, normalise, round.
module fp_cvt_pipe
    import fp_cvt_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned MW = MW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat
);

    localparam int unsigned CW    = $clog2(DW + 1);
    localparam int unsigned ESPAN = 2 ** EW;

    if (DW != fp_dw(EW, MW)) begin : g_cfg_check
        $error("fp_cvt_pipe: DW must equal 2**EW + MW");
    end

    typedef struct packed {
        logic          s;
        logic          sat;
        logic          rnd;
        logic [DW-1:0] mag;
    } st1_t;

    typedef struct packed {
        logic          s;
        logic          sat;
        logic          rnd;
        logic          rbit;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
    } st2_t;

    typedef struct packed {
        logic          s;
        logic          sat;
        logic [EW-1:0] e;
        logic [MW-1:0] f;
    } st3_t;

    logic          advance_c;
    logic [CW-1:0] lz_c;
    logic [EW-1:0] norm_e_c;
    logic [MW-1:0] norm_f_c;
    logic          norm_rbit_c;

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s3_vld_q, s3_vld_d;
    st1_t s1_q, s1_d;
    st2_t s2_q, s2_d;
    st3_t s3_q, s3_d;

    // Whole pipe moves in lockstep; it only stops when a held result is refused.
    assign advance_c = !s3_vld_q || out_ready;
    assign in_ready  = advance_c;

    // Stage 1: sign and magnitude, clamping the one magnitude that does not fit.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        if (advance_c) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_d.s   = in_data[DW-1];
                s1_d.rnd = in_rnd;
                s1_d.sat = 1'b0;
                s1_d.mag = in_data[DW-1] ? (~in_data + DW'(1)) : in_data;
                if (in_data == {1'b1, {(DW-1){1'b0}}}) begin
                    s1_d.sat = 1'b1;
                    s1_d.mag = {1'b0, {(DW-1){1'b1}}};
                end
            end
        end
    end

    fp_lzc #(
        .DW (DW)
    ) u_lzc (
        .data (s1_q.mag),
        .lz_c (lz_c)
    );

    // Exponent, significand window and round bit from the leading-zero count.
    always_comb begin
        norm_e_c    = '0;
        norm_rbit_c = 1'b0;
        if (32'(lz_c) < ESPAN) begin
            norm_e_c = EW'(ESPAN - 32'(lz_c));
        end
        norm_f_c = MW'(s1_q.mag >> norm_e_c);
        if (norm_e_c != '0) begin
            norm_rbit_c = 1'(s1_q.mag >> (norm_e_c - EW'(1)));
        end
    end

    // Stage 2: register the normalised fields.
    always_comb begin
        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (advance_c) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_d.s    = s1_q.s;
                s2_d.sat  = s1_q.sat;
                s2_d.rnd  = s1_q.rnd;
                s2_d.rbit = norm_rbit_c;
                s2_d.e    = norm_e_c;
                s2_d.f    = norm_f_c;
            end
        end
    end

    // Stage 3: optional half-up rounding with renormalisation and saturation.
    always_comb begin
        s3_vld_d = s3_vld_q;
        s3_d     = s3_q;
        if (advance_c) begin
            s3_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                s3_d.s   = s2_q.s;
                s3_d.sat = s2_q.sat;
                s3_d.e   = s2_q.e;
                s3_d.f   = s2_q.f;
                if ((s2_q.rnd == RND_HALF_UP) && s2_q.rbit) begin
                    if (&s2_q.f) begin
                        if (&s2_q.e) begin
                            s3_d.e   = '1;
                            s3_d.f   = '1;
                            s3_d.sat = 1'b1;
                        end else begin
                            s3_d.e         = s2_q.e + EW'(1);
                            s3_d.f         = '0;
                            s3_d.f[MW-1]   = 1'b1;
                        end
                    end else begin
                        s3_d.f = s2_q.f + MW'(1);
                    end
                end
            end
        end
    end

    // Pipeline registers; reset drops every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s3_vld_q <= s3_vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
        end
    end

    assign out_valid = s3_vld_q;
    assign out_s     = s3_q.s;
    assign out_e     = s3_q.e;
    assign out_f     = s3_q.f;
    assign out_sat   = s3_q.sat;

endmodule

// File: tb/tb_fp_cvt_pipe.sv
// Bench for fp_cvt_pipe: directed cases, stall/reset scenarios and a random
// scoreboard run on the default and a wide (EW=4 MW=4 DW=20) instance.
module tb_fp_cvt_pipe;

    localparam int NRAND = 10000;

    logic clk;
    logic rst;

    logic        a_iv, a_ir, a_r, a_ov, a_or, a_s, a_sat;
    logic [11:0] a_d;
    logic [2:0]  a_e;
    logic [3:0]  a_f;

    logic        b_iv, b_ir, b_r, b_ov, b_or, b_s, b_sat;
    logic [19:0] b_d;
    logic [3:0]  b_e;
    logic [3:0]  b_f;

    int total = 0;
    int bad   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          a_hold = 0, b_hold = 0;
    logic [31:0] a_held, b_held;
    int          a_rx = 0;

    logic [11:0] stall_data [6] = '{12'd422, 12'd125, 12'h800, 12'd2047, 12'hFFF, 12'd7};

    fp_cvt_pipe #(.EW(3), .MW(4), .DW(12)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_iv),
        .in_ready  (a_ir),
        .in_data   (a_d),
        .in_rnd    (a_r),
        .out_valid (a_ov),
        .out_ready (a_or),
        .out_s     (a_s),
        .out_e     (a_e),
        .out_f     (a_f),
        .out_sat   (a_sat)
    );

    fp_cvt_pipe #(.EW(4), .MW(4), .DW(20)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_iv),
        .in_ready  (b_ir),
        .in_data   (b_d),
        .in_rnd    (b_r),
        .out_valid (b_ov),
        .out_ready (b_or),
        .out_s     (b_s),
        .out_e     (b_e),
        .out_f     (b_f),
        .out_sat   (b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = F*2^E with F holding the MW bits from the leading one down.
    function automatic logic [31:0] ref_cvt(input int ew, input int mw, input longint data, input bit rnd);
        int     dw, msb, e, f, s, sat;
        longint mag, maxmag;
        dw     = (1 << ew) + mw;
        maxmag = (longint'(1) << (dw - 1)) - 1;
        s      = (data < 0) ? 1 : 0;
        mag    = (data < 0) ? -data : data;
        sat    = 0;
        if (mag > maxmag) begin
            mag = maxmag;
            sat = 1;
        end
        msb = -1;
        for (int i = 0; i < dw; i++) if (((mag >> i) & 1) == 1) msb = i;
        e = msb - mw + 1;
        if (e < 0) e = 0;
        f = int'(mag >> e);
        if (rnd && e > 0 && (((mag >> (e - 1)) & 1) == 1)) begin
            f = f + 1;
            if (f == (1 << mw)) begin
                if (e == (1 << ew) - 1) begin
                    f   = (1 << mw) - 1;
                    sat = 1;
                end else begin
                    f = 1 << (mw - 1);
                    e = e + 1;
                end
            end
        end
        return 32'((sat << (1 + ew + mw)) | (s << (ew + mw)) | (e << mw) | f);
    endfunction

    function automatic logic [31:0] obs_a();
        return 32'({a_sat, a_s, a_e, a_f});
    endfunction

    function automatic logic [31:0] obs_b();
        return 32'({b_sat, b_s, b_e, b_f});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after inputs are driven at a negedge: scoreboard both instances.
    task automatic observe();
        #1;
        if (a_iv && a_ir) qa.push_back(ref_cvt(3, 4, longint'($signed(a_d)), a_r));
        if (b_iv && b_ir) qb.push_back(ref_cvt(4, 4, longint'($signed(b_d)), b_r));
        if (a_ov && a_or) begin
            a_rx++;
            if (qa.size() == 0) chk("a_unexpected_out", 32'(a_ov), 32'd0);
            else                chk("a_result", obs_a(), qa.pop_front());
        end
        if (b_ov && b_or) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(b_ov), 32'd0);
            else                chk("b_result", obs_b(), qb.pop_front());
        end
        if (a_hold) begin
            chk("a_hold_valid", 32'(a_ov), 32'd1);
            chk("a_hold_data", obs_a(), a_held);
        end
        if (b_hold) begin
            chk("b_hold_valid", 32'(b_ov), 32'd1);
            chk("b_hold_data", obs_b(), b_held);
        end
        if (a_ov && !a_or) begin
            chk("a_stall_in_ready", 32'(a_ir), 32'd0);
            a_hold = 1;
            a_held = obs_a();
        end else a_hold = 0;
        if (b_ov && !b_or) begin
            chk("b_stall_in_ready", 32'(b_ir), 32'd0);
            b_hold = 1;
            b_held = obs_b();
        end else b_hold = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst  = 1'b1;
        a_iv = 1'b0;
        b_iv = 1'b0;
        a_or = 1'b1;
        b_or = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        qa.delete();
        qb.delete();
        a_hold = 0;
        b_hold = 0;
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_out_data", obs_a(), 32'd0);
        chk("rst_in_ready", 32'(a_ir), 32'd1);
        chk("rst_b_out_valid", 32'(b_ov), 32'd0);
    endtask

    // Single sample on the default instance against hand-derived results.
    task automatic run_one(input string tag, input logic [11:0] d, input bit r,
                           input int es, input int ee, input int ef, input int esat);
        int lat;
        @(negedge clk);
        a_iv = 1'b1;
        a_d  = d;
        a_r  = r;
        a_or = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(a_ir), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            a_iv = 1'b0;
            lat++;
        end while (!a_ov && lat < 10);
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_s"}, 32'(a_s), 32'(es));
        chk({tag, "_e"}, 32'(a_e), 32'(ee));
        chk({tag, "_f"}, 32'(a_f), 32'(ef));
        chk({tag, "_sat"}, 32'(a_sat), 32'(esat));
        @(negedge clk);
        #1 chk({tag, "_drained"}, 32'(a_ov), 32'd0);
    endtask

    initial begin
        int          sent, a_sent, b_sent, cyc, rx0;
        logic [31:0] r;

        rst  = 1'b1;
        a_iv = 1'b0; a_d = '0; a_r = 1'b0; a_or = 1'b1;
        b_iv = 1'b0; b_d = '0; b_r = 1'b0; b_or = 1'b1;

        do_reset(2);

        run_one("zero",      12'd0,    1'b1, 0, 0, 0,  0);
        run_one("d422",      12'd422,  1'b1, 0, 5, 13, 0);
        run_one("d125_rnd",  12'd125,  1'b1, 0, 4, 8,  0);
        run_one("d125_trn",  12'd125,  1'b0, 0, 3, 15, 0);
        run_one("mostneg",   12'h800,  1'b1, 1, 7, 15, 1);
        run_one("mostneg_t", 12'h800,  1'b0, 1, 7, 15, 1);
        run_one("max_rnd",   12'd2047, 1'b1, 0, 7, 15, 1);
        run_one("max_trn",   12'd2047, 1'b0, 0, 7, 15, 0);
        run_one("minus1",    12'hFFF,  1'b1, 1, 0, 1,  0);

        // Back-to-back stream with a five-cycle consumer stall in the middle.
        sent = 0;
        rx0  = a_rx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a_iv = (sent < 6);
            a_d  = stall_data[(sent < 6) ? sent : 0];
            a_r  = 1'b1;
            a_or = !(c >= 5 && c < 10);
            observe();
            if (a_iv && a_ir) sent++;
        end
        chk("stall_results", 32'(a_rx - rx0), 32'd6);
        chk("stall_queue_empty", 32'(qa.size()), 32'd0);

        // Fill all three stages, then reset: nothing in flight may surface.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_iv = 1'b1;
            a_d  = 12'(100 * (i + 1));
            a_r  = 1'b1;
            a_or = 1'b0;
            observe();
        end
        @(negedge clk);
        a_iv = 1'b0;
        observe();
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_or = 1'b1;
            observe();
        end
        run_one("post_rst", 12'd422, 1'b1, 0, 5, 13, 0);

        // Random traffic on both widths, scoreboarded against the reference.
        a_sent = 0;
        b_sent = 0;
        cyc    = 0;
        while ((a_sent < NRAND || b_sent < NRAND) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            r    = $urandom >> $urandom_range(0, 31);
            a_d  = r[11:0];
            if ($urandom_range(0, 63) == 0) a_d = 12'h800;
            a_iv = (a_sent < NRAND) && ($urandom_range(0, 3) != 0);
            a_r  = 1'($urandom);
            a_or = ($urandom_range(0, 3) != 0);
            r    = $urandom >> $urandom_range(0, 31);
            b_d  = r[19:0];
            if ($urandom_range(0, 63) == 0) b_d = 20'h80000;
            b_iv = (b_sent < NRAND) && ($urandom_range(0, 3) != 0);
            b_r  = 1'($urandom);
            b_or = ($urandom_range(0, 3) != 0);
            observe();
            if (a_iv && a_ir) a_sent++;
            if (b_iv && b_ir) b_sent++;
        end
        chk("rand_a_sent", 32'(a_sent), 32'(NRAND));
        chk("rand_b_sent", 32'(b_sent), 32'(NRAND));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_iv = 1'b0;
            b_iv = 1'b0;
            a_or = 1'b1;
            b_or = 1'b1;
            observe();
        end
        chk("rand_a_drained", 32'(qa.size()), 32'd0);
        chk("rand_b_drained", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_cvt_pipe.md
# fp_cvt_pipe

Parametrised, pipelined successor to the lab-1 linear-to-floating-point converter. Accepts a DW-bit two's-complement sample and produces sign, EW-bit exponent and MW-bit significand (value = F·2^E) through a three-stage pipeline with valid/ready handshakes, per-sample rounding mode and a saturation flag. Sits between the sample source and any display/encoder consumer that applies backpressure.

## Interface
- EW, 3, exponent width
- MW, 4, significand width
- DW, 12, input width; must equal 2^EW + MW (elaboration error otherwise)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  converter accepts sample this cycle
- in_data  in  DW  two's-complement sample
- in_rnd  in  1  rounding mode for this sample: 0 truncate, 1 round-half-up
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_s  out  1  sign
- out_e  out  EW  exponent
- out_f  out  MW  significand
- out_sat  out  1  result was clamped

## Operation
- Transfer on a port occurs when valid && ready both high at a rising edge.
- Stage 1 (sign/magnitude): S = in_data[DW-1]; mag = |in_data|; most-negative input (-2^(DW-1)) clamps to 2^(DW-1)-1 and sets sat.
- Stage 2 (normalise): lz = leading zeros of mag (DW bits, lz ≥ 1 always). E = 2^EW − lz if lz < 2^EW, else 0. F = mag[E+MW-1 : E]; rbit = mag[E-1] if E > 0, else 0.
- Stage 3 (round): if in_rnd=0 or rbit=0, pass through. Else F+1; on carry out of F, F = 1000…0 (MW bits), E+1; if E was already 2^EW−1, result is E = all ones, F = all ones, sat = 1.
- S, in_rnd, sat travel with their sample; stages never mix samples.
- Zero input -> S=0, E=0, F=0, sat=0.

## Timing
- Latency 3 cycles from input transfer to out_valid with out_ready held high; throughput one sample per cycle.
- Global advance = !out_valid || out_ready; in_ready = advance (combinational). All three stages (data and valid) load only when advance=1; bubbles are not collapsed.
- While out_valid=1 and out_ready=0: out_* held stable, in_ready=0, no sample lost or duplicated, order preserved.
- Simultaneous input and output transfer in the same cycle is legal and required at full rate.
- Reset: all stage valid bits clear; out_valid=0, out_s=0, out_e=0, out_f=0, out_sat=0. in_ready=1 in the first cycle after reset. Reset mid-stream discards all in-flight samples; no partial result emerges.
- in_data/in_rnd are don't-care when in_valid=0.

## Structure
- Package fp_cvt_pkg: default EW/MW/DW constants, rounding-mode encodings (RND_TRUNC=0, RND_HALF_UP=1), stage payload struct (s, sat, rnd, mag/e/f/rbit).
- One sub-module: fp_lzc, parametrised combinational leading-zero counter over DW bits, instantiated in stage 2.
- Remaining logic (pipeline registers, handshake, rounding) lives in fp_cvt_pipe.

## Test plan
- Defaults, rnd=1, out_ready=1: in_data=0 -> S0 E0 F0 sat0; in_data=422 -> S0 E5 F13 sat0, 3 cycles later.
- in_data=125, rnd=1 -> rounding carry: S0 E4 F8; same with rnd=0 -> S0 E3 F15.
- in_data=0x800 (-2048), rnd=1 -> S1 E7 F15 sat1; in_data=2047 rnd=1 -> S0 E7 F15 sat1; rnd=0 -> sat0. in_data=0xFFF -> S1 E0 F1.
- Stream 6 back-to-back samples, drop out_ready for 5 cycles mid-stream -> in_ready low during stall, outputs stable, all 6 results in order, none duplicated.
- Assert rst for one cycle with 3 samples in flight -> out_valid=0 next cycle, all outputs 0, no stale result ever appears; next sample after reset has 3-cycle latency.
- Random 10k samples, random in_valid/out_ready/in_rnd, also EW=4 MW=4 DW=20 -> every output matches scoreboard reference model bit-exactly.
